// File: rtl/fp16_add_seq.sv
// Multi-cycle FP16 adder: align one bit per cycle, add/subtract magnitudes,
// normalise one step per cycle. Truncating, subnormals flushed to zero.
module fp16_add_seq #(
  parameter int ALIGN_CAP = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic        sgn1_reg, sgn1_next;
  logic        sgn2_reg, sgn2_next;
  logic        sign_reg, sign_next;
  logic [4:0]  exp_reg, exp_next;
  logic [4:0]  diff_reg, diff_next;
  logic [10:0] mant1_reg, mant1_next;
  logic [10:0] mant2_reg, mant2_next;
  logic [11:0] sum_reg, sum_next;
  logic [15:0] out_sum_reg, out_sum_next;

  // Operand unpacking; index 0 is A, index 1 is B.
  logic [15:0] op      [2];
  logic [4:0]  op_exp  [2];
  logic [10:0] op_mant [2];
  logic        swap;
  logic [4:0]  exp_inc;

  assign op[0] = in_a;
  assign op[1] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_exp[gi]  = op[gi][14:10];
      assign op_mant[gi] = (op[gi][14:10] != 5'd0) ? {1'b1, op[gi][9:0]} : 11'd0;
    end
  endgenerate

  // Ties keep A as the larger-exponent operand.
  assign swap    = op_exp[1] > op_exp[0];
  assign exp_inc = exp_reg + 5'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      sgn1_reg    <= 1'b0;
      sgn2_reg    <= 1'b0;
      sign_reg    <= 1'b0;
      exp_reg     <= 5'd0;
      diff_reg    <= 5'd0;
      mant1_reg   <= 11'd0;
      mant2_reg   <= 11'd0;
      sum_reg     <= 12'd0;
      out_sum_reg <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      sgn1_reg    <= sgn1_next;
      sgn2_reg    <= sgn2_next;
      sign_reg    <= sign_next;
      exp_reg     <= exp_next;
      diff_reg    <= diff_next;
      mant1_reg   <= mant1_next;
      mant2_reg   <= mant2_next;
      sum_reg     <= sum_next;
      out_sum_reg <= out_sum_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sgn1_next    = sgn1_reg;
    sgn2_next    = sgn2_reg;
    sign_next    = sign_reg;
    exp_next     = exp_reg;
    diff_next    = diff_reg;
    mant1_next   = mant1_reg;
    mant2_next   = mant2_reg;
    sum_next     = sum_reg;
    out_sum_next = out_sum_reg;

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sgn1_next  = swap ? op[1][15]  : op[0][15];
          sgn2_next  = swap ? op[0][15]  : op[1][15];
          exp_next   = swap ? op_exp[1]  : op_exp[0];
          mant1_next = swap ? op_mant[1] : op_mant[0];
          mant2_next = swap ? op_mant[0] : op_mant[1];
          diff_next  = swap ? (op_exp[1] - op_exp[0]) : (op_exp[0] - op_exp[1]);
          state_next = ALIGN;
        end
      end

      ALIGN: begin
        if (diff_reg == 5'd0) begin
          state_next = ADD;
        end else if (int'(diff_reg) >= ALIGN_CAP) begin
          // Far too small to contribute: drop it in a single step.
          mant2_next = 11'd0;
          diff_next  = 5'd0;
        end else begin
          mant2_next = mant2_reg >> 1;
          diff_next  = diff_reg - 5'd1;
        end
      end

      ADD: begin
        if (sgn1_reg == sgn2_reg) begin
          sum_next  = {1'b0, mant1_reg} + {1'b0, mant2_reg};
          sign_next = sgn1_reg;
        end else if (mant1_reg >= mant2_reg) begin
          sum_next  = {1'b0, mant1_reg - mant2_reg};
          sign_next = sgn1_reg;
        end else begin
          sum_next  = {1'b0, mant2_reg - mant1_reg};
          sign_next = sgn2_reg;
        end
        state_next = NORM;
      end

      NORM: begin
        if (sum_reg == 12'd0) begin
          out_sum_next = 16'h0000;
          state_next   = DONE;
        end else if (sum_reg[11]) begin
          sum_next = sum_reg >> 1;
          exp_next = exp_inc;
          if (exp_inc == 5'd31) begin
            out_sum_next = {sign_reg, 5'd31, 10'd0};
            state_next   = DONE;
          end
        end else if (!sum_reg[10] && exp_reg > 5'd1) begin
          sum_next = sum_reg << 1;
          exp_next = exp_reg - 5'd1;
        end else if (!sum_reg[10]) begin
          // Would go subnormal: flush to positive zero.
          out_sum_next = 16'h0000;
          state_next   = DONE;
        end else begin
          out_sum_next = {sign_reg, exp_reg, sum_reg[9:0]};
          state_next   = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_sum   = out_sum_reg;

endmodule
